fetch_pc_unit: RTL

- Instruction-fetch front end that sits directly upstream of InstMem.
- Owns the program counter and drives the Pc address into InstMem, whose registered InstReg has one cycle of read latency.
- Tracks which PC the instruction currently on InstReg belongs to, and marks it valid or invalid for decode.
- Handles sequential fetch, branch and jump redirects, stall, and halt.

---
 rtl/fetch_pc_unit_pkg.sv | 24 ++
 rtl/fetch_pc_unit_if.sv | 28 ++
 rtl/fetch_pc_unit_next_pc_sel.sv | 37 +++
 rtl/fetch_pc_unit.sv | 119 +++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and address helpers for the instruction-fetch front end.
// All PCs live in a word-aligned space of IMEM_WORDS*4 bytes.
package fetch_pc_unit_pkg;

   localparam int unsigned PC_W = 32;

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;
   typedef enum logic [1:0] {SEL_HALT, SEL_REDIR, SEL_STALL, SEL_SEQ} sel_e;

   function automatic logic [PC_W-1:0] addr_mask(input int unsigned imem_words);
      return PC_W'(imem_words * 4) - PC_W'(1);
   endfunction

   function automatic logic [PC_W-1:0] sanitize_addr(input logic [PC_W-1:0] addr,
                                                     input int unsigned     imem_words);
      return addr & addr_mask(imem_words) & ~PC_W'(3);
   endfunction

   function automatic logic addr_bad(input logic [PC_W-1:0] addr,
                                     input int unsigned     imem_words);
      return (addr[1:0] != 2'b00) || ((addr & ~addr_mask(imem_words)) != '0);
   endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control/status bundle between the fetch unit and its decode/branch neighbours.
interface fetch_pc_unit_if;
   import fetch_pc_unit_pkg::*;

   logic            stall;
   logic            branch_taken;
   logic [PC_W-1:0] branch_target;
   logic            jump;
   logic [PC_W-1:0] jump_target;
   logic            halt;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] fetch_pc;
   logic [PC_W-1:0] fetch_pc_plus4;
   logic            fetch_valid;
   logic            halted;
   logic            addr_err;

   modport master (
      output stall, branch_taken, branch_target, jump, jump_target, halt,
      input  pc, fetch_pc, fetch_pc_plus4, fetch_valid, halted, addr_err
   );

   modport slave (
      input  stall, branch_taken, branch_target, jump, jump_target, halt,
      output pc, fetch_pc, fetch_pc_plus4, fetch_valid, halted, addr_err
   );

endinterface

// File: rtl/fetch_pc_unit_next_pc_sel.sv
// Combinational next-PC priority select: halt > branch > jump > stall > sequential,
// with redirect-target sanitising and bad-target detection.
module next_pc_sel
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = 1024
) (
   input  logic            halt_i,
   input  logic            branch_taken_i,
   input  logic [PC_W-1:0] branch_target_i,
   input  logic            jump_i,
   input  logic [PC_W-1:0] jump_target_i,
   input  logic            stall_i,
   input  logic [PC_W-1:0] pc_q_i,
   output sel_e            sel_o,
   output logic [PC_W-1:0] redir_pc_o,
   output logic            addr_err_set_o,
   output logic [PC_W-1:0] pc_plus4_o
);

   logic [PC_W-1:0] target;

   always_comb begin
      // Branch comes from the older instruction, so a simultaneous jump is dropped.
      target = branch_taken_i ? branch_target_i : jump_target_i;

      sel_o = SEL_SEQ;
      if (halt_i)                        sel_o = SEL_HALT;
      else if (branch_taken_i || jump_i) sel_o = SEL_REDIR;
      else if (stall_i)                  sel_o = SEL_STALL;

      redir_pc_o     = sanitize_addr(target, IMEM_WORDS);
      addr_err_set_o = (sel_o == SEL_REDIR) && addr_bad(target, IMEM_WORDS);
      pc_plus4_o     = sanitize_addr(pc_q_i + PC_W'(4), IMEM_WORDS);
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch-tag tracking in front of a 1-cycle-latency InstMem.
// FetchPc/FetchValid describe the instruction InstMem is presenting on InstReg.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 1024
) (
   input  logic            clk_i,
   input  logic            rst_i,
   fetch_pc_unit_if.slave  bus_if
);

   localparam logic [PC_W-1:0] RESET_PC_PLUS4 = sanitize_addr(RESET_PC + PC_W'(4), IMEM_WORDS);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0] fetch_pc_plus4_q, fetch_pc_plus4_d;
   logic            fetch_valid_q, fetch_valid_d;
   logic            addr_err_q, addr_err_d;

   sel_e            sel;
   logic [PC_W-1:0] redir_pc;
   logic            addr_err_set;
   logic [PC_W-1:0] pc_plus4;

   next_pc_sel #(.IMEM_WORDS(IMEM_WORDS)) u_next_pc_sel (
      .halt_i          (bus_if.halt),
      .branch_taken_i  (bus_if.branch_taken),
      .branch_target_i (bus_if.branch_target),
      .jump_i          (bus_if.jump),
      .jump_target_i   (bus_if.jump_target),
      .stall_i         (bus_if.stall),
      .pc_q_i          (pc_q),
      .sel_o           (sel),
      .redir_pc_o      (redir_pc),
      .addr_err_set_o  (addr_err_set),
      .pc_plus4_o      (pc_plus4)
   );

   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      fetch_pc_d       = fetch_pc_q;
      fetch_pc_plus4_d = fetch_pc_plus4_q;
      fetch_valid_d    = fetch_valid_q;
      addr_err_d       = addr_err_q;

      unique case (state_q)
         S_BOOT: begin
            fetch_pc_d       = pc_q;
            fetch_pc_plus4_d = pc_plus4;
            pc_d             = pc_plus4;
            fetch_valid_d    = 1'b1;
            state_d          = S_RUN;
         end
         S_RUN: begin
            unique case (sel)
               SEL_HALT: begin
                  state_d       = S_HALT;
                  fetch_valid_d = 1'b0;
               end
               // InstMem captures the old PcReg at this edge: tag it, but mark it wrong-path.
               SEL_REDIR: begin
                  fetch_pc_d       = pc_q;
                  fetch_pc_plus4_d = pc_plus4;
                  pc_d             = redir_pc;
                  fetch_valid_d    = 1'b0;
                  addr_err_d       = addr_err_q | addr_err_set;
               end
               SEL_STALL: begin
               end
               SEL_SEQ: begin
                  fetch_pc_d       = pc_q;
                  fetch_pc_plus4_d = pc_plus4;
                  pc_d             = pc_plus4;
                  fetch_valid_d    = 1'b1;
               end
               default: begin
               end
            endcase
         end
         S_HALT: begin
            fetch_valid_d = 1'b0;
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q          <= S_BOOT;
         pc_q             <= RESET_PC;
         fetch_pc_q       <= RESET_PC;
         fetch_pc_plus4_q <= RESET_PC_PLUS4;
         fetch_valid_q    <= 1'b0;
         addr_err_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         fetch_pc_q       <= fetch_pc_d;
         fetch_pc_plus4_q <= fetch_pc_plus4_d;
         fetch_valid_q    <= fetch_valid_d;
         addr_err_q       <= addr_err_d;
      end
   end

   // During a plain stall InstMem re-reads the held instruction so InstReg stays put.
   assign bus_if.pc             = (state_q == S_RUN && sel == SEL_STALL) ? fetch_pc_q : pc_q;
   assign bus_if.fetch_pc       = fetch_pc_q;
   assign bus_if.fetch_pc_plus4 = fetch_pc_plus4_q;
   assign bus_if.fetch_valid    = fetch_valid_q;
   assign bus_if.halted         = (state_q == S_HALT);
   assign bus_if.addr_err       = addr_err_q;

endmodule
